pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences bring-up of an iCE40 PLL clock generator and the reset of the logic it drives. The block pulses the PLL reset and waits for a stable lock, then holds system reset for a fixed time before releasing it. On PLL failure it retries a bounded number of times, and on loss of lock it re-sequences. It runs in the 12 MHz reference domain, between the board clock input and the PLL-clocked design's reset tree.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before reset release begins.
- RESET_HOLD_CYCLES, 16: cycles system_reset stays high after lock is qualified.
- PLL_RESET_CYCLES, 8: cycles pll_reset is held high per attempt.
- LOCK_TIMEOUT_CYCLES, 65536: cycles in WAIT_LOCK before an attempt is declared failed.
- MAX_RETRIES, 3: failed attempts before entering FAIL.

- clock_in  input  1  12 MHz reference clock; the only clock.
- reset  input  1  synchronous, active-high.
- locked_in  input  1  PLL lock flag; asynchronous to clock_in.
- restart  input  1  single-cycle request to re-run the full sequence.
- pll_reset  output  1  active-high PLL reset; the PLL RESETB pin is driven by its inverse.
- system_reset  output  1  active-high reset for downstream logic.
- ready  output  1  high only in RUN.
- failed  output  1  high only in FAIL.
- lock_loss_count  output  8  saturating count of lock losses seen in RUN.
- state  output  3  current state encoding, for debug.

## Operation
- locked_in passes through a 2-flop synchronizer that resets to 0. Its output is locked_s.
- States and encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAIL=5.
- One shared cycle counter, sized $clog2 of the largest parameter +1. It clears on every state change.
- retries is a counter of width $clog2(MAX_RETRIES+1).
- PLL_RST: after PLL_RESET_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 → STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1, increment retries.
  - If retries+1 == MAX_RETRIES, go to FAIL; else go to PLL_RST.
- STABLE:
  - locked_s=0 → WAIT_LOCK, with the timeout restarted.
  - After LOCK_STABLE_CYCLES consecutive cycles → HOLD.
- HOLD:
  - locked_s=0 → WAIT_LOCK.
  - After RESET_HOLD_CYCLES cycles → RUN, and retries clears.
- RUN:
  - locked_s=0 → PLL_RST.
  - lock_loss_count increments, saturating at 255.
- FAIL: terminal. Only restart or reset leaves it.
- restart=1 in any state → PLL_RST, with retries and the counter cleared. restart has priority over every other transition.
- restart and locked_s=0 in the same RUN cycle: go to PLL_RST. lock_loss_count still increments.
- restart while already in PLL_RST restarts the PLL_RESET_CYCLES count.
- Outputs are registered decodes of the next state, so they change on the same edge as state:
  - pll_reset = (state==PLL_RST)
  - system_reset = (state!=RUN)
  - ready = (state==RUN)
  - failed = (state==FAIL)

## Timing
- Values while reset is high, and on the first edge after:
  - state=PLL_RST, pll_reset=1, system_reset=1.
  - ready=0, failed=0.
  - lock_loss_count=0, retries=0, synchronizer=0.
- The sequence starts on the first edge with reset=0. Cycle 0 is the first cycle in PLL_RST.
- Lock latency: a locked_in edge reaches locked_s 2 cycles later. The FSM reacts on the next edge.
- With locked_in constantly high, state durations are:
  - PLL_RST: P cycles.
  - WAIT_LOCK: 1 cycle (the synchronizer fills during PLL_RST).
  - STABLE: L cycles.
  - HOLD: H cycles.
  - ready rises at cycle P+1+L+H.
- Lock loss in RUN: system_reset and pll_reset rise 3 edges after locked_in falls. ready falls on the same edge.
- A single-cycle low glitch on locked_in shorter than one clock may be missed. Any glitch captured in STABLE or HOLD restarts qualification.
- Assertion of reset mid-sequence returns every output to its reset value on the next edge. lock_loss_count is cleared.

## Test plan
Parameters for all scenarios: P=8, L=16, H=4, LOCK_TIMEOUT_CYCLES=64, MAX_RETRIES=3.

1. Clean bring-up, locked_in=1 throughout:
   - pll_reset high for cycles 0–7.
   - ready and system_reset=0 from cycle 29 onward; state=4.
2. Lock never asserts:
   - Three PLL_RST/WAIT_LOCK rounds, with pll_reset pulsed 3 times.
   - failed=1 and state=5 after the third timeout; system_reset stays 1.
3. Lock loss in RUN: drop locked_in for 5 cycles, then raise it.
   - pll_reset=1 three edges after the drop; lock_loss_count=1.
   - ready returns after the full re-sequence.
4. Glitch during STABLE: locked_in low for 2 cycles midway.
   - State returns to WAIT_LOCK.
   - ready is delayed by a fresh L=16 qualification.
5. restart while in FAIL, with locked_in=1:
   - failed=0 on the next edge; retries cleared.
   - ready high 29 cycles later.
6. Saturation and priority:
   - 260 lock-loss events → lock_loss_count=255.
   - restart coincident with lock loss → state=0 and the counter increments.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock qualification with bounded retries, then timed system reset release.
module pll_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int PLL_RESET_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked_in,
  input  logic       restart,
  output logic       pll_reset,
  output logic       system_reset,
  output logic       ready,
  output logic       failed,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);
  localparam int MAX_LH = LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_PT = PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_C  = MAX_LH > MAX_PT ? MAX_LH : MAX_PT;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);
  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] HOLD      = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] FAIL      = 3'd5;
  logic          sync1, locked_s;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retries;
  logic [2:0]    nxt;
  logic          rst_done, timeout, stable_done, hold_done, last_try;
  always_comb begin
    rst_done    = cnt == CW'(PLL_RESET_CYCLES - 1);
    timeout     = cnt == CW'(LOCK_TIMEOUT_CYCLES - 1);
    stable_done = cnt == CW'(LOCK_STABLE_CYCLES - 1);
    hold_done   = cnt == CW'(RESET_HOLD_CYCLES - 1);
    last_try    = int'(retries) + 1 == MAX_RETRIES;
    nxt = PLL_RST;
    case (state)
      PLL_RST:   nxt = rst_done ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: nxt = locked_s ? STABLE : !timeout ? WAIT_LOCK : last_try ? FAIL : PLL_RST;
      STABLE:    nxt = !locked_s ? WAIT_LOCK : stable_done ? HOLD : STABLE;
      HOLD:      nxt = !locked_s ? WAIT_LOCK : hold_done ? RUN : HOLD;
      RUN:       nxt = locked_s ? RUN : PLL_RST;
      FAIL:      nxt = FAIL;
      default:   nxt = PLL_RST;
    endcase
    if (restart) nxt = PLL_RST;
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1           <= 1'b0;
      locked_s        <= 1'b0;
      state           <= PLL_RST;
      cnt             <= '0;
      retries         <= '0;
      lock_loss_count <= '0;
      pll_reset       <= 1'b1;
      system_reset    <= 1'b1;
      ready           <= 1'b0;
      failed          <= 1'b0;
    end else begin
      sync1    <= locked_in;
      locked_s <= sync1;
      state    <= nxt;
      cnt      <= (restart || nxt != state) ? '0 : cnt + 1'b1;
      if (restart)
        retries <= '0;
      else if (state == WAIT_LOCK && !locked_s && timeout)
        retries <= retries + 1'b1;
      else if (state == HOLD && locked_s && hold_done)
        retries <= '0;
      if (state == RUN && !locked_s && lock_loss_count != 8'hff)
        lock_loss_count <= lock_loss_count + 1'b1;
      pll_reset    <= nxt == PLL_RST;
      system_reset <= nxt != RUN;
      ready        <= nxt == RUN;
      failed       <= nxt == FAIL;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scoreboard bench, stimulus queues cycle-stamped expectations and a monitor checks them.
module tb_pll_reset_sequencer;
  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       locked_in = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, system_reset, ready, failed;
  logic [7:0] lock_loss_count;
  logic [2:0] state;
  typedef struct {
    int          at;
    logic [14:0] v;
    string       nm;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int base = 0;
  int n = 0;
  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES(16),
    .RESET_HOLD_CYCLES(4),
    .PLL_RESET_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .MAX_RETRIES(3)
  ) dut (
    .clock_in(clock_in),
    .reset(reset),
    .locked_in(locked_in),
    .restart(restart),
    .pll_reset(pll_reset),
    .system_reset(system_reset),
    .ready(ready),
    .failed(failed),
    .lock_loss_count(lock_loss_count),
    .state(state)
  );
  always #5 clock_in = ~clock_in;
  initial forever begin
    @(posedge clock_in);
    cyc++;
  end
  function automatic logic [14:0] mk(logic [2:0] st, logic [7:0] llc);
    return {st, st == 3'd0, st != 3'd4, st == 3'd4, st == 3'd5, llc};
  endfunction
  task automatic expect_at(int c, int st, int llc, string nm);
    exp_t e;
    int i;
    e.at = c;
    e.v  = mk(3'(st), 8'(llc));
    e.nm = nm;
    i = q.size();
    while (i > 0 && q[i-1].at > c) i--;
    q.insert(i, e);
  endtask
  task automatic ex(int k, int st, int llc, string nm);
    expect_at(base + k, st, llc, nm);
  endtask
  task automatic tick(int k);
    repeat (k) @(negedge clock_in);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    expect_at(cyc + 1, 0, 0, "reset_vals");
    tick(4);
    reset = 1'b0;
    base = cyc;
  endtask
  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(posedge clock_in);
      #2;
      act = {state, pll_reset, system_reset, ready, failed, lock_loss_count};
      while (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (e.at < cyc) begin
          n_bad++;
          $display("FAIL %s: sample for cycle %0d missed", e.nm, e.at);
        end else if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s @%0d: got st=%0d pr=%b sr=%b rd=%b fl=%b llc=%0d, want st=%0d pr=%b sr=%b rd=%b fl=%b llc=%0d",
                   e.nm, cyc, act[14:12], act[11], act[10], act[9], act[8], act[7:0],
                   e.v[14:12], e.v[11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
        end
      end
    end
  end
  initial begin
    @(negedge clock_in);
    locked_in = 1'b1;
    do_reset();
    ex(1, 0, 0, "s1_prst_c1");
    ex(7, 0, 0, "s1_prst_c7");
    ex(8, 1, 0, "s1_wait");
    ex(9, 2, 0, "s1_stable");
    ex(24, 2, 0, "s1_stable_end");
    ex(25, 3, 0, "s1_hold");
    ex(28, 3, 0, "s1_hold_end");
    ex(29, 4, 0, "s1_run");
    tick(40);
    n = cyc;
    locked_in = 1'b0;
    expect_at(n + 2, 4, 0, "s3_still_run");
    expect_at(n + 3, 0, 1, "s3_pll_rst");
    expect_at(n + 10, 0, 1, "s3_prst_end");
    expect_at(n + 11, 1, 1, "s3_wait");
    expect_at(n + 12, 2, 1, "s3_stable");
    expect_at(n + 31, 3, 1, "s3_hold_end");
    expect_at(n + 32, 4, 1, "s3_run");
    tick(5);
    locked_in = 1'b1;
    tick(35);
    do_reset();
    ex(16, 2, 0, "s4_stable_pre");
    ex(17, 1, 0, "s4_glitch_wait");
    ex(18, 1, 0, "s4_wait2");
    ex(19, 2, 0, "s4_requalify");
    ex(34, 2, 0, "s4_stable_end");
    ex(35, 3, 0, "s4_hold");
    ex(38, 3, 0, "s4_hold_end");
    ex(39, 4, 0, "s4_run");
    tick(14);
    locked_in = 1'b0;
    tick(2);
    locked_in = 1'b1;
    tick(30);
    locked_in = 1'b0;
    do_reset();
    ex(7, 0, 0, "s2_prst1_end");
    ex(8, 1, 0, "s2_wait1");
    ex(71, 1, 0, "s2_wait1_end");
    ex(72, 0, 0, "s2_prst2");
    ex(80, 1, 0, "s2_wait2");
    ex(144, 0, 0, "s2_prst3");
    ex(151, 0, 0, "s2_prst3_end");
    ex(152, 1, 0, "s2_wait3");
    ex(215, 1, 0, "s2_wait3_end");
    ex(216, 5, 0, "s2_fail");
    ex(229, 5, 0, "s2_fail_sticky");
    tick(230);
    n = cyc;
    restart = 1'b1;
    expect_at(n + 1, 0, 0, "s5a_restart");
    expect_at(n + 8, 0, 0, "s5a_prst_end");
    expect_at(n + 9, 1, 0, "s5a_wait");
    expect_at(n + 216, 1, 0, "s5a_wait3_end");
    expect_at(n + 217, 5, 0, "s5a_fail_again");
    tick(1);
    restart = 1'b0;
    tick(219);
    n = cyc;
    locked_in = 1'b1;
    restart = 1'b1;
    expect_at(n + 1, 0, 0, "s5b_restart");
    expect_at(n + 8, 0, 0, "s5b_prst_end");
    expect_at(n + 9, 1, 0, "s5b_wait");
    expect_at(n + 29, 3, 0, "s5b_hold_end");
    expect_at(n + 30, 4, 0, "s5b_run");
    tick(1);
    restart = 1'b0;
    tick(33);
    n = cyc;
    locked_in = 1'b0;
    expect_at(n + 2, 4, 0, "s6_prio_run");
    expect_at(n + 3, 0, 1, "s6_prio_rst");
    expect_at(n + 32, 4, 1, "s6_prio_run_again");
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    locked_in = 1'b1;
    tick(31);
    for (int k = 2; k <= 260; k++) begin
      n = cyc;
      locked_in = 1'b0;
      if (k <= 3 || k >= 253) expect_at(n + 3, 0, k > 255 ? 255 : k, "s6_sat");
      tick(3);
      locked_in = 1'b1;
      tick(31);
    end
    expect_at(cyc + 1, 4, 255, "s6_final_run");
    for (int i = 0; i < 100 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
